draw_span_writer: RTL and testbench

Parametrised successor to the row drawer. Consumes a stream of decoded pixels and writes one horizontal span into the frame buffer, stepping the target position in 16.16 fixed point per pixel. It generalises pixel width (8/16/32), adds a posted write buffer of configurable depth, a ready/valid pixel handshake, and per-pixel byte enables. It optionally adds clip-window rejection. It sits between the pixel decoder and the frame-buffer memory port in the madam draw path.

---
 rtl/draw_span_writer.sv | 222 ++++++++++++++++++++++
 tb/tb_draw_span_writer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_span_writer.sv
// Span writer: steps a 16.16 position per pixel, queues {addr, wdata, be} writes in a posted FIFO.
// Optional clip-window rejection is enabled by defining DRAW_SPAN_CLIP_EN.
module draw_span_writer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int PIXEL_WIDTH = 16,
    parameter int PIPE_LEN    = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   req,
    input  logic [ADDR_WIDTH-1:0]  fb_base,
    input  logic [31:0]            stride,
    input  logic [31:0]            xcur_in,
    input  logic [31:0]            ycur_in,
    input  logic [31:0]            hdx,
    input  logic [31:0]            hdy,
    input  logic [31:0]            cnt_in,
    input  logic [15:0]            clip_xmin,
    input  logic [15:0]            clip_xmax,
    input  logic [15:0]            clip_ymin,
    input  logic [15:0]            clip_ymax,
    input  logic                   transp_en,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic [PIXEL_WIDTH-1:0] pix_data,
    input  logic                   pix_transp,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic [3:0]             mem_be,
    input  logic                   mem_ack,
    output logic                   busy,
    output logic                   done
);

    localparam int PTR_W     = $clog2(PIPE_LEN);
    localparam int BPP_SHIFT = $clog2(PIXEL_WIDTH / 8);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(PIPE_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [3:0]            be;
    } entry_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fb_base_q, fb_base_d;
    logic [31:0]           stride_q, stride_d;
    logic [31:0]           xacc_q, xacc_d, yacc_q, yacc_d;
    logic [31:0]           hdx_q, hdx_d, hdy_q, hdy_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  transp_en_q, transp_en_d;
    logic                  done_q, done_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    entry_t                fifo_q [PIPE_LEN];

    logic signed [15:0]    xpos, ypos;
    logic [ADDR_WIDTH-1:0] x_ext, y_ext, pix_addr;
    logic [3:0]            pix_be;
    entry_t                entry_d, head;
    logic                  fifo_full, consume, clipped, skip, push, pop;

    assign xpos = xacc_q[31:16];
    assign ypos = yacc_q[31:16];

`ifdef DRAW_SPAN_CLIP_EN
    logic signed [15:0] cxmin_q, cxmax_q, cymin_q, cymax_q;
    logic signed [15:0] cxmin_d, cxmax_d, cymin_d, cymax_d;

    always_comb begin
        cxmin_d = cxmin_q;
        cxmax_d = cxmax_q;
        cymin_d = cymin_q;
        cymax_d = cymax_q;
        if (state_q == ST_IDLE && req) begin
            cxmin_d = clip_xmin;
            cxmax_d = clip_xmax;
            cymin_d = clip_ymin;
            cymax_d = clip_ymax;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cxmin_q <= '0;
            cxmax_q <= '0;
            cymin_q <= '0;
            cymax_q <= '0;
        end else begin
            cxmin_q <= cxmin_d;
            cxmax_q <= cxmax_d;
            cymin_q <= cymin_d;
            cymax_q <= cymax_d;
        end
    end

    assign clipped = (xpos < cxmin_q) || (xpos > cxmax_q) || (ypos < cymin_q) || (ypos > cymax_q);
`else
    logic unused_clip;
    assign unused_clip = ^{clip_xmin, clip_xmax, clip_ymin, clip_ymax};
    assign clipped     = 1'b0;
`endif

    // Sign-extended products wrap modulo 2^ADDR_WIDTH, matching signed arithmetic.
    always_comb begin
        x_ext    = {{(ADDR_WIDTH-16){xpos[15]}}, xpos};
        y_ext    = {{(ADDR_WIDTH-16){ypos[15]}}, ypos};
        pix_addr = fb_base_q + y_ext * ADDR_WIDTH'(stride_q) + (x_ext << BPP_SHIFT);
        if (PIXEL_WIDTH == 8) begin
            pix_be = 4'b0001 << pix_addr[1:0];
        end else if (PIXEL_WIDTH == 16) begin
            pix_be = pix_addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            pix_be = 4'hF;
        end
        entry_d       = '0;
        entry_d.addr  = {pix_addr[ADDR_WIDTH-1:2], 2'b00};
        entry_d.wdata = {(DATA_WIDTH / PIXEL_WIDTH){pix_data}};
        entry_d.be    = pix_be;
    end

    assign head      = fifo_q[rd_ptr_q];
    assign fifo_full = (count_q == FULL_CNT);
    assign consume   = (state_q == ST_RUN) && pix_valid && !fifo_full;
    assign skip      = (transp_en_q && pix_transp) || clipped;
    assign push      = consume && !skip;
    assign pop       = mem_req && mem_ack;

    always_comb begin
        state_d     = state_q;
        fb_base_d   = fb_base_q;
        stride_d    = stride_q;
        xacc_d      = xacc_q;
        yacc_d      = yacc_q;
        hdx_d       = hdx_q;
        hdy_d       = hdy_q;
        cnt_d       = cnt_q;
        transp_en_d = transp_en_q;
        done_d      = 1'b0;
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        count_d     = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    fb_base_d   = fb_base;
                    stride_d    = stride;
                    xacc_d      = xcur_in;
                    yacc_d      = ycur_in;
                    hdx_d       = hdx;
                    hdy_d       = hdy;
                    cnt_d       = cnt_in;
                    transp_en_d = transp_en;
                    state_d     = (cnt_in == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (consume) begin
                    cnt_d  = cnt_q - 32'd1;
                    xacc_d = xacc_q + hdx_q;
                    yacc_d = yacc_q + hdy_q;
                    if (cnt_q == 32'd1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            fb_base_q   <= '0;
            stride_q    <= '0;
            xacc_q      <= '0;
            yacc_q      <= '0;
            hdx_q       <= '0;
            hdy_q       <= '0;
            cnt_q       <= '0;
            transp_en_q <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fb_base_q   <= fb_base_d;
            stride_q    <= stride_d;
            xacc_q      <= xacc_d;
            yacc_q      <= yacc_d;
            hdx_q       <= hdx_d;
            hdy_q       <= hdy_d;
            cnt_q       <= cnt_d;
            transp_en_q <= transp_en_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            if (push) fifo_q[wr_ptr_q] <= entry_d;
        end
    end

    assign pix_ready = consume;
    assign mem_req   = (count_q != '0);
    assign mem_we    = mem_req;
    assign mem_addr  = mem_req ? head.addr  : '0;
    assign mem_wdata = mem_req ? head.wdata : '0;
    assign mem_be    = mem_req ? head.be    : '0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_draw_span_writer.sv
// Scoreboard bench for draw_span_writer: 16-bit and 8-bit pixel instances share one stimulus driver.
module tb_draw_span_writer;

    localparam int PIPE_LEN = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aresetn, req16, req8, transp_en, pix_valid, pix_transp, mem_ack;
    logic [31:0] fb_base, stride, xcur_in, ycur_in, hdx, hdy, cnt_in;
    logic [15:0] clip_xmin, clip_xmax, clip_ymin, clip_ymax, pix_data;

    logic        pix_ready_16, mem_req_16, mem_we_16, busy_16, done_16;
    logic [31:0] mem_addr_16, mem_wdata_16;
    logic [3:0]  mem_be_16;
    logic        pix_ready_8, mem_req_8, mem_we_8, busy_8, done_8;
    logic [31:0] mem_addr_8, mem_wdata_8;
    logic [3:0]  mem_be_8;

    logic        sel8, mon_en;
    logic        m_ready, m_req, m_we, m_busy, m_done;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_writes = 0;
    int   n_done   = 0;
    exp_t exp_q[$];

    draw_span_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .PIXEL_WIDTH(16), .PIPE_LEN(PIPE_LEN)) dut16 (
        .aclk(clk), .aresetn(aresetn), .req(req16), .fb_base(fb_base), .stride(stride),
        .xcur_in(xcur_in), .ycur_in(ycur_in), .hdx(hdx), .hdy(hdy), .cnt_in(cnt_in),
        .clip_xmin(clip_xmin), .clip_xmax(clip_xmax), .clip_ymin(clip_ymin), .clip_ymax(clip_ymax),
        .transp_en(transp_en), .pix_valid(pix_valid), .pix_ready(pix_ready_16), .pix_data(pix_data),
        .pix_transp(pix_transp), .mem_req(mem_req_16), .mem_we(mem_we_16), .mem_addr(mem_addr_16),
        .mem_wdata(mem_wdata_16), .mem_be(mem_be_16), .mem_ack(mem_ack), .busy(busy_16), .done(done_16)
    );

    draw_span_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .PIXEL_WIDTH(8), .PIPE_LEN(PIPE_LEN)) dut8 (
        .aclk(clk), .aresetn(aresetn), .req(req8), .fb_base(fb_base), .stride(stride),
        .xcur_in(xcur_in), .ycur_in(ycur_in), .hdx(hdx), .hdy(hdy), .cnt_in(cnt_in),
        .clip_xmin(clip_xmin), .clip_xmax(clip_xmax), .clip_ymin(clip_ymin), .clip_ymax(clip_ymax),
        .transp_en(transp_en), .pix_valid(pix_valid), .pix_ready(pix_ready_8), .pix_data(pix_data[7:0]),
        .pix_transp(pix_transp), .mem_req(mem_req_8), .mem_we(mem_we_8), .mem_addr(mem_addr_8),
        .mem_wdata(mem_wdata_8), .mem_be(mem_be_8), .mem_ack(mem_ack), .busy(busy_8), .done(done_8)
    );

    assign m_ready = sel8 ? pix_ready_8 : pix_ready_16;
    assign m_req   = sel8 ? mem_req_8   : mem_req_16;
    assign m_we    = sel8 ? mem_we_8    : mem_we_16;
    assign m_busy  = sel8 ? busy_8      : busy_16;
    assign m_done  = sel8 ? done_8      : done_16;
    assign m_addr  = sel8 ? mem_addr_8  : mem_addr_16;
    assign m_wdata = sel8 ? mem_wdata_8 : mem_wdata_16;
    assign m_be    = sel8 ? mem_be_8    : mem_be_16;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t make_exp(input bit pw8, input logic [31:0] fb, input logic [31:0] st,
                                      input logic signed [15:0] xs, input logic signed [15:0] ys,
                                      input logic [15:0] pd);
        exp_t        e;
        logic [31:0] a;
        int          xi, yi;
        xi = xs;
        yi = ys;
        a = fb + yi * st + xi * (pw8 ? 1 : 2);
        e.addr = {a[31:2], 2'b00};
        if (pw8) begin
            e.be    = 4'b0001 << a[1:0];
            e.wdata = {4{pd[7:0]}};
        end else begin
            e.be    = a[1] ? 4'b1100 : 4'b0011;
            e.wdata = {2{pd}};
        end
        return e;
    endfunction

    // Every cycle a write is presented it must match the scoreboard head; it pops on ack.
    always @(negedge clk) begin
        if (aresetn && mon_en) begin
            if (m_req) begin
                check_val("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check_val("wr_addr", m_addr, exp_q[0].addr);
                    check_val("wr_data", m_wdata, exp_q[0].wdata);
                    check_val("wr_be", 32'(m_be), 32'(exp_q[0].be));
                    check_val("wr_we", 32'(m_we), 32'd1);
                    if (mem_ack) begin
                        void'(exp_q.pop_front());
                        n_writes++;
                    end
                end
            end
            if (m_done) begin
                n_done++;
                check_val("busy_at_done", 32'(m_busy), 32'd0);
            end
        end
    end

    task automatic run_span(input string name, input bit pw8, input logic [31:0] fb, input logic [31:0] st,
                            input logic [31:0] x, input logic [31:0] y, input logic [31:0] hx,
                            input logic [31:0] hy, input int n, input bit ten, input logic [31:0] tmask,
                            input int ack_low, input logic [15:0] pd, input logic [15:0] pd_inc);
        logic [31:0]        xa, ya;
        logic signed [15:0] xs, ys;
        logic [15:0]        cur_pd;
        int                 i, c, n_exp, consumed_low;
        bit                 skip;
        @(negedge clk);
        sel8 = pw8; fb_base = fb; stride = st; xcur_in = x; ycur_in = y;
        hdx = hx; hdy = hy; cnt_in = n; transp_en = ten; mem_ack = 1'b1;
        n_writes = 0; n_done = 0;
        if (pw8) req8 = 1'b1; else req16 = 1'b1;
        @(negedge clk);
        req8 = 1'b0; req16 = 1'b0;
        check_val({name, "_busy_rise"}, 32'(m_busy), 32'd1);
        xa = x; ya = y; i = 0; c = 0; n_exp = 0; consumed_low = 0;
        while (i < n && c < 400) begin
            cur_pd     = pd + pd_inc * 16'(i);
            mem_ack    = (c >= ack_low);
            pix_valid  = 1'b1;
            pix_data   = cur_pd;
            pix_transp = tmask[i];
            #1;
            if (m_ready) begin
                if (!mem_ack) consumed_low++;
                xs   = xa[31:16];
                ys   = ya[31:16];
                skip = ten && tmask[i];
`ifdef DRAW_SPAN_CLIP_EN
                if (xs < $signed(clip_xmin) || xs > $signed(clip_xmax) ||
                    ys < $signed(clip_ymin) || ys > $signed(clip_ymax)) skip = 1'b1;
`endif
                if (!skip) begin
                    exp_q.push_back(make_exp(pw8, fb, st, xs, ys, cur_pd));
                    n_exp++;
                end
                xa = xa + hx;
                ya = ya + hy;
                i++;
            end
            @(negedge clk);
            c++;
        end
        pix_valid = 1'b0; pix_transp = 1'b0; mem_ack = 1'b1;
        check_val({name, "_consumed"}, i, n);
        if (ack_low == 0) check_val({name, "_throughput"}, c, n);
        else check_val({name, "_bp_pushes"}, consumed_low, PIPE_LEN);
        for (int k = 0; k < 60 && n_done == 0; k++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        check_val({name, "_done_cnt"}, n_done, 1);
        check_val({name, "_writes"}, n_writes, n_exp);
        check_val({name, "_sb_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn = 1'b0; req16 = 1'b0; req8 = 1'b0; sel8 = 1'b0; mon_en = 1'b1;
        fb_base = '0; stride = '0; xcur_in = '0; ycur_in = '0; hdx = '0; hdy = '0; cnt_in = '0;
        clip_xmin = 16'h8000; clip_xmax = 16'h7fff; clip_ymin = 16'h8000; clip_ymax = 16'h7fff;
        transp_en = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_transp = 1'b0; mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_pix_ready", 32'(pix_ready_16), 32'd0);
        check_val("rst_mem_req", 32'(mem_req_16), 32'd0);
        check_val("rst_mem_we", 32'(mem_we_16), 32'd0);
        check_val("rst_mem_addr", mem_addr_16, 32'd0);
        check_val("rst_mem_wdata", mem_wdata_16, 32'd0);
        check_val("rst_mem_be", 32'(mem_be_16), 32'd0);
        check_val("rst_busy", 32'(busy_16), 32'd0);
        check_val("rst_done", 32'(done_16), 32'd0);
        check_val("rst_mem_req8", 32'(mem_req_8), 32'd0);
        aresetn = 1'b1;

        run_span("basic", 1'b0, 32'h0, 32'h500, 32'h000A_0000, 32'h000A_0000, 32'h0001_0000, 32'h0,
                 10, 1'b0, 32'h0, 0, 16'h7fff, 16'h0);
        run_span("backpr", 1'b0, 32'h0, 32'h500, 32'h000A_0000, 32'h000A_0000, 32'h0001_0000, 32'h0,
                 10, 1'b0, 32'h0, 20, 16'h1000, 16'h0101);
        run_span("transp", 1'b0, 32'h0, 32'h500, 32'h000A_0000, 32'h000A_0000, 32'h0001_0000, 32'h0,
                 10, 1'b1, 32'h0000_0088, 0, 16'h2000, 16'h0003);
        run_span("diag8", 1'b1, 32'h1000, 32'h40, 32'h0, 32'h0, 32'h0000_8000, 32'h0001_0000,
                 4, 1'b0, 32'h0, 0, 16'h00A5, 16'h0001);
        run_span("negx", 1'b0, 32'h8000, 32'h100, 32'hFFFE_0000, 32'h0001_0000, 32'h0001_0000, 32'h0,
                 5, 1'b0, 32'h0, 0, 16'h1234, 16'h1111);
        clip_xmin = 16'd3; clip_xmax = 16'd5; clip_ymin = 16'hFF9C; clip_ymax = 16'd100;
        run_span("clip", 1'b0, 32'h2000, 32'h100, 32'h0, 32'h0002_0000, 32'h0001_0000, 32'h0,
                 10, 1'b0, 32'h0, 0, 16'h4321, 16'h0010);
        clip_xmin = 16'h8000; clip_xmax = 16'h7fff; clip_ymin = 16'h8000; clip_ymax = 16'h7fff;

        // Zero-length span: one busy cycle, then done, no pixel consumed.
        @(negedge clk);
        sel8 = 1'b0; cnt_in = 32'd0; n_writes = 0; n_done = 0; pix_valid = 1'b1; req16 = 1'b1;
        @(negedge clk);
        req16 = 1'b0;
        check_val("cnt0_busy", 32'(busy_16), 32'd1);
        check_val("cnt0_done_early", 32'(done_16), 32'd0);
        check_val("cnt0_ready", 32'(pix_ready_16), 32'd0);
        @(negedge clk);
        check_val("cnt0_busy_fall", 32'(busy_16), 32'd0);
        check_val("cnt0_done", 32'(done_16), 32'd1);
        @(negedge clk);
        check_val("cnt0_done_pulse", 32'(done_16), 32'd0);
        check_val("cnt0_writes", n_writes, 0);
        pix_valid = 1'b0;

        // Abort mid-span with entries stalled in the buffer.
        mon_en = 1'b0; mem_ack = 1'b0;
        fb_base = 32'h0; stride = 32'h500; xcur_in = 32'h0; ycur_in = 32'h0;
        hdx = 32'h0001_0000; hdy = 32'h0; cnt_in = 32'd10; req16 = 1'b1;
        @(negedge clk);
        req16 = 1'b0; pix_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_val("abort_pre_req", 32'(mem_req_16), 32'd1);
        check_val("abort_pre_busy", 32'(busy_16), 32'd1);
        aresetn = 1'b0;
        @(negedge clk);
        check_val("abort_mem_req", 32'(mem_req_16), 32'd0);
        check_val("abort_busy", 32'(busy_16), 32'd0);
        check_val("abort_ready", 32'(pix_ready_16), 32'd0);
        check_val("abort_mem_be", 32'(mem_be_16), 32'd0);
        aresetn = 1'b1; pix_valid = 1'b0; mem_ack = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;

        run_span("post_rst", 1'b0, 32'h100, 32'h20, 32'h0003_0000, 32'h0001_0000, 32'h0001_0000, 32'h0,
                 3, 1'b0, 32'h0, 0, 16'hBEEF, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
